// File: rtl/alu_exec_pkg_rv32i.sv
// Shared constants for the RV32I execute stage: op codes, FSM states and shift kinds.
package alu_exec_pkg_rv32i;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd2;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd3;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
  localparam logic [OP_W-1:0] OP_OR   = 4'd8;
  localparam logic [OP_W-1:0] OP_AND  = 4'd9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_kind_e;

endpackage

// File: rtl/alu_serial_shifter_rv32i.sv
// One-bit-per-cycle shifter; done/result are presented combinationally on the
// cycle whose edge takes the counter from 1 to 0, so the caller can register them.
module alu_serial_shifter_rv32i
  import alu_exec_pkg_rv32i::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               kill,
  input  shift_kind_e        kind,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [XLEN-1:0]    operand,
  output logic               done,
  output logic [XLEN-1:0]    result
);

  logic [XLEN-1:0]    work_q;
  logic [SHAMT_W-1:0] cnt_q;
  shift_kind_e        kind_q;
  logic [XLEN-1:0]    step;

  always_comb begin
    step = work_q;
    case (kind_q)
      SH_LL:   step = {work_q[XLEN-2:0], 1'b0};
      SH_RL:   step = {1'b0, work_q[XLEN-1:1]};
      SH_RA:   step = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: step = work_q;
    endcase
  end

  assign done   = (cnt_q == SHAMT_W'(1)) && !kill;
  assign result = step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      kind_q <= SH_LL;
    end else if (kill) begin
      cnt_q <= '0;
    end else if (start) begin
      work_q <= operand;
      cnt_q  <= shamt;
      kind_q <= kind;
    end else if (cnt_q != '0) begin
      work_q <= step;
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_stage_rv32i.sv
// RV32I execute stage: single-cycle ALU ops plus serial shifts, valid/ready on
// both sides and a synchronous flush.
module alu_exec_stage_rv32i
  import alu_exec_pkg_rv32i::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal,
  output logic            busy
);

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [RD_W-1:0] out_rd_q, out_rd_d;
  logic            out_illegal_q, out_illegal_d;
  logic [RD_W-1:0] shift_rd_q, shift_rd_d;

  logic               accept, is_shift, sh_start, sh_done;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res, sh_result;
  logic               alu_ill;
  shift_kind_e        sh_kind;

  assign in_ready = (state_q == ST_IDLE) && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = in_b[SHAMT_W-1:0];
  assign is_shift = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
  assign sh_start = accept && is_shift && (shamt != '0);

  // Single-cycle datapath; zero-amount shifts pass operand A through.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    sh_kind = SH_LL;
    case (in_op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_SLT:  alu_res = XLEN'($signed(in_a) < $signed(in_b));
      OP_SLTU: alu_res = XLEN'(in_a < in_b);
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_SLL:  alu_res = in_a;
      OP_SRL: begin
        alu_res = in_a;
        sh_kind = SH_RL;
      end
      OP_SRA: begin
        alu_res = in_a;
        sh_kind = SH_RA;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  alu_serial_shifter_rv32i u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (sh_start),
    .kill    (flush),
    .kind    (sh_kind),
    .shamt   (shamt),
    .operand (in_a),
    .done    (sh_done),
    .result  (sh_result)
  );

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q && !out_ready;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    shift_rd_d    = shift_rd_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sh_start) begin
            state_d    = ST_SHIFT;
            shift_rd_d = in_rd;
          end else if (accept) begin
            out_valid_d   = 1'b1;
            out_result_d  = alu_res;
            out_rd_d      = in_rd;
            out_illegal_d = alu_ill;
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            state_d       = ST_IDLE;
            out_valid_d   = 1'b1;
            out_result_d  = sh_result;
            out_rd_d      = shift_rd_q;
            out_illegal_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
      shift_rd_q    <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
      shift_rd_q    <= shift_rd_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_illegal_q;
  assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_alu_exec_stage_rv32i.sv
// Directed-vector bench for alu_exec_stage_rv32i with hand-computed expectations.
module tb_alu_exec_stage_rv32i;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_illegal, busy;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_rd, out_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_stage_rv32i dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    #1;
  endtask

  // Issue one single-cycle op with out_ready=1 and check it one cycle later.
  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input logic exp_ill);
    drive(op, a, b, rd);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, out_result, exp);
    chk({tag, "_rd"}, 32'(out_rd), 32'(rd));
    chk({tag, "_ill"}, 32'(out_illegal), 32'(exp_ill));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
    tick(); tick();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_res", out_result, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_ill", 32'(out_illegal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // ADD then SUB back to back
    single("add", 4'd0, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0);
    single("sub", 4'd1, 32'd0, 32'd1, 5'd4, 32'hFFFF_FFFF, 1'b0);
    tick();
    chk("drain_vld", 32'(out_valid), 32'd0);

    single("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 5'd1, 32'd1, 1'b0);
    single("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 5'd1, 32'd0, 1'b0);
    single("slt_eq", 4'd3, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'd0, 1'b0);
    single("xor", 4'd5, 32'h0000_00F0, 32'h0000_00FF, 5'd8, 32'h0000_000F, 1'b0);
    single("or", 4'd8, 32'h0000_00F0, 32'h0000_000F, 5'd9, 32'h0000_00FF, 1'b0);

    // SRA by 4 with junk in the upper shamt bits
    drive(4'd7, 32'h8000_0000, 32'h0000_0024, 5'd10);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sra_busy", 32'(busy), 32'd1);
      chk("sra_rdy", 32'(in_ready), 32'd0);
      chk("sra_vld_early", 32'(out_valid), 32'd0);
      tick();
    end
    chk("sra_vld", 32'(out_valid), 32'd1);
    chk("sra_res", out_result, 32'hF800_0000);
    chk("sra_rd", 32'(out_rd), 32'd10);
    chk("sra_busy_end", 32'(busy), 32'd0);
    single("sll0", 4'd2, 32'd1, 32'd0, 5'd11, 32'd1, 1'b0);
    tick();

    // Backpressure
    out_ready = 1'b0;
    single("bp_add", 4'd0, 32'd1, 32'd1, 5'd5, 32'd2, 1'b0);
    drive(4'd9, 32'h0000_00F0, 32'h0000_003C, 5'd6);
    chk("bp_rdy0", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_vld", 32'(out_valid), 32'd1);
    chk("bp_hold_res", out_result, 32'd2);
    chk("bp_hold_rd", 32'(out_rd), 32'd5);
    chk("bp_rdy1", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy2", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_and_vld", 32'(out_valid), 32'd1);
    chk("bp_and_res", out_result, 32'h0000_0030);
    chk("bp_and_rd", 32'(out_rd), 32'd6);
    tick();

    // SRL by 31 killed by flush 10 cycles after accept
    drive(4'd6, 32'hFFFF_FFFF, 32'd31, 5'd12);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("fl_busy_pre", 32'(busy), 32'd1);
    flush = 1'b1;
    drive(4'd0, 32'd100, 32'd1, 5'd13);
    chk("fl_rdy_in_flush", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_vld", 32'(out_valid), 32'd0);
    chk("fl_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("fl_no_result", 32'(out_valid), 32'd0);
    end
    single("post_fl_add", 4'd0, 32'd3, 32'd4, 5'd7, 32'd7, 1'b0);

    single("illegal", 4'hF, 32'd9, 32'd9, 5'd2, 32'd0, 1'b1);
    single("add2", 4'd0, 32'd3, 32'd4, 5'd7, 32'd7, 1'b0);

    // Async reset in the middle of a shift
    drive(4'd2, 32'd1, 32'd8, 5'd14);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_busy", 32'(busy), 32'd1);
    chk("mr_res_stale", out_result, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_busy0", 32'(busy), 32'd0);
    chk("mr_vld", 32'(out_valid), 32'd0);
    chk("mr_res", out_result, 32'd0);
    chk("mr_rd", 32'(out_rd), 32'd0);
    chk("mr_ill", 32'(out_illegal), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mr_no_result", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
